// File: rtl/start_signal_pkg.sv
// Shared constants and helpers for the start-signal AXI4-Lite slave.
// Register indices, response codes and the byte-strobe merge.
package start_signal_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] IDX_CTRL   = 32'd0;
    localparam logic [31:0] IDX_STATUS = 32'd1;
    localparam logic [31:0] IDX_DONE   = 32'd2;
    localparam logic [31:0] IDX_IRQEN  = 32'd3;
    localparam logic [31:0] IDX_USER0  = 32'd4;

    // Replace only the bytes whose strobe is set; sized for the widest bus.
    function automatic logic [63:0] strb_merge(
        input logic [63:0] cur,
        input logic [63:0] wdata,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = cur;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/start_signal_chan.sv
// One start/done channel: start pulse, busy tracking and sticky done.
// A start on a busy channel is dropped; a done set beats a clear.
module start_signal_chan (
    input  logic clk,
    input  logic rst_n,
    input  logic start_req,
    input  logic done_in,
    input  logic clr_done,
    output logic start_o,
    output logic busy_o,
    output logic done_o
);

    logic fire;

    assign fire = start_req & ~busy_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            start_o <= fire;
            busy_o  <= (busy_o & ~done_in) | fire;
            done_o  <= done_in | (done_o & ~clr_done);
        end
    end

endmodule

// File: rtl/start_signal_ctrl.sv
// AXI4-Lite slave issuing per-channel start pulses and tracking done state.
// Holds the AXI handshakes, register file and interrupt; channels are generated.
module start_signal_ctrl
    import start_signal_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int NUM_USER_REGS      = 4
) (
    input  logic                                        ACLK,
    input  logic                                        ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
    input  logic [2:0]                                  S_AXI_AWPROT,
    input  logic                                        S_AXI_AWVALID,
    output logic                                        S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
    input  logic                                        S_AXI_WVALID,
    output logic                                        S_AXI_WREADY,
    output logic [1:0]                                  S_AXI_BRESP,
    output logic                                        S_AXI_BVALID,
    input  logic                                        S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
    input  logic [2:0]                                  S_AXI_ARPROT,
    input  logic                                        S_AXI_ARVALID,
    output logic                                        S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
    output logic [1:0]                                  S_AXI_RRESP,
    output logic                                        S_AXI_RVALID,
    input  logic                                        S_AXI_RREADY,
    output logic [NUM_CH-1:0]                           start_o,
    input  logic [NUM_CH-1:0]                           done_i,
    output logic [NUM_USER_REGS*C_S_AXI_DATA_WIDTH-1:0] user_regs_o,
    output logic                                        irq_o
);

    localparam int W        = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = $clog2(W / 8);
    localparam int NREGS    = 4 + NUM_USER_REGS;

    logic          awready_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [1:0]    rresp_q;
    logic [W-1:0]  rdata_q;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   w_idx;
    logic [31:0]   r_idx;
    logic          w_ok;
    logic          r_ok;
    logic [W-1:0]  rd_word;
    logic [NUM_CH-1:0] start_req;
    logic [NUM_CH-1:0] clr_done;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] irq_en;
    logic [W-1:0]  user_reg [NUM_USER_REGS];
    logic          unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign w_idx = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);
    assign r_idx = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);
    assign w_ok  = w_idx < 32'(NREGS);
    assign r_ok  = r_idx < 32'(NREGS);
    assign wr_en = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en = arready_q & S_AXI_ARVALID;

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    // Ready drops after one cycle so back-to-back acceptance is impossible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (r_idx)
            IDX_STATUS: rd_word[NUM_CH-1:0] = busy;
            IDX_DONE:   rd_word[NUM_CH-1:0] = done;
            IDX_IRQEN:  rd_word[NUM_CH-1:0] = irq_en;
            default:    rd_word = '0;
        endcase
        for (int k = 0; k < NUM_USER_REGS; k++) begin
            if (r_idx == IDX_USER0 + 32'(k)) rd_word = user_reg[k];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rresp_q  <= r_ok ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= r_ok ? rd_word : '0;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_en <= '0;
            irq_o  <= 1'b0;
            for (int k = 0; k < NUM_USER_REGS; k++) user_reg[k] <= '0;
        end else begin
            irq_o <= |(done & irq_en);
            if (wr_en && w_idx == IDX_IRQEN) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (S_AXI_WSTRB[c/8]) irq_en[c] <= S_AXI_WDATA[c];
                end
            end
            for (int k = 0; k < NUM_USER_REGS; k++) begin
                if (wr_en && w_idx == IDX_USER0 + 32'(k)) begin
                    user_reg[k] <= W'(strb_merge(64'(user_reg[k]),
                                                 64'(S_AXI_WDATA),
                                                 8'(S_AXI_WSTRB)));
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_USER_REGS; k++) begin : g_user
        assign user_regs_o[k*W +: W] = user_reg[k];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign start_req[c] = wr_en && w_idx == IDX_CTRL
                              && S_AXI_WSTRB[c/8] && S_AXI_WDATA[c];
        assign clr_done[c]  = wr_en && w_idx == IDX_DONE
                              && S_AXI_WSTRB[c/8] && S_AXI_WDATA[c];

        start_signal_chan u_chan (
            .clk       (ACLK),
            .rst_n     (ARESETN),
            .start_req (start_req[c]),
            .done_in   (done_i[c]),
            .clr_done  (clr_done[c]),
            .start_o   (start_o[c]),
            .busy_o    (busy[c]),
            .done_o    (done[c])
        );
    end

endmodule

// File: tb/tb_start_signal_ctrl.sv
// Directed bench for start_signal_ctrl: register table plus
// start/done, interrupt, backpressure and reset sequences.
module tb_start_signal_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [3:0]   start_o;
    logic [3:0]   done_i;
    logic [127:0] user_regs;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    start_signal_ctrl dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .start_o       (start_o),
        .done_i        (done_i),
        .user_regs_o   (user_regs),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_o != 4'b0) pulse_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_wr(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
    endtask

    task automatic wait_aw(input logic [3:0] d_at_hs);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 50);
        chk("awready", 128'(awready), 128'(1));
        done_i = d_at_hs;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        done_i  = 4'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid", 128'(bvalid), 128'(1));
        resp = bresp;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bready = 1'b1;
        start_wr(a, d, s);
        wait_aw(4'b0);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        chk("arready", 128'(arready), 128'(1));
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid", 128'(rvalid), 128'(1));
        d    = rdata;
        resp = rresp;
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk(name, 128'(d), 128'(exp));
        chk({name, "_rresp"}, 128'(r), 128'(0));
    endtask

    task automatic wr_ok(input logic [5:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, 4'hF, r);
        chk("bresp_ok", 128'(r), 128'(0));
    endtask

    task automatic done_pulse();
        @(negedge clk);
        done_i = 4'b0001;
        @(negedge clk);
        done_i = 4'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int base;

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        done_i = '0;

        vecs.push_back('{1'b0, 6'h04, 32'h0,        4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h08, 32'h0,        4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h0C, 32'h0,        4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 6'h10, 32'h1,        4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 6'h14, 32'h2,        4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 6'h18, 32'h3,        4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 6'h1C, 32'h4,        4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h10, 32'h0,        4'h0, 32'h1,        2'b00});
        vecs.push_back('{1'b0, 6'h14, 32'h0,        4'h0, 32'h2,        2'b00});
        vecs.push_back('{1'b0, 6'h18, 32'h0,        4'h0, 32'h3,        2'b00});
        vecs.push_back('{1'b0, 6'h1C, 32'h0,        4'h0, 32'h4,        2'b00});
        vecs.push_back('{1'b1, 6'h10, 32'hAABBCCDD, 4'h2, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h10, 32'h0,        4'h0, 32'h0000CC01, 2'b00});
        vecs.push_back('{1'b0, 6'h11, 32'h0,        4'h0, 32'h0000CC01, 2'b00});
        vecs.push_back('{1'b1, 6'h3C, 32'h12345678, 4'hF, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 6'h10, 32'h0,        4'h0, 32'h0000CC01, 2'b00});
        vecs.push_back('{1'b1, 6'h04, 32'hF,        4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h04, 32'h0,        4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h00, 32'h0,        4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 6'h0C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h0C, 32'h0,        4'h0, 32'hF,        2'b00});
        vecs.push_back('{1'b1, 6'h0C, 32'h0,        4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 6'h0C, 32'h0,        4'h0, 32'h0,        2'b00});

        repeat (3) @(negedge clk);
        chk("rst_awready", 128'(awready), 128'(0));
        chk("rst_bvalid", 128'(bvalid), 128'(0));
        chk("rst_rvalid", 128'(rvalid), 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_irq", 128'(irq), 128'(0));
        chk("rst_start", 128'(start_o), 128'(0));
        chk("rst_user", user_regs, 128'(0));

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), 128'(r),
                    128'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), 128'(d),
                    128'(vecs[i].exp_data));
                chk($sformatf("vec%0d_rresp", i), 128'(r),
                    128'(vecs[i].exp_resp));
            end
        end
        chk("user_regs_o", user_regs,
            {32'd4, 32'd3, 32'd2, 32'h0000CC01});

        // start on channel 0, then a dropped start while busy
        base = pulse_cnt;
        wr_ok(6'h00, 32'h1);
        repeat (3) @(negedge clk);
        chk("start_pulse_cycles", 128'(pulse_cnt - base), 128'(1));
        rd_chk("status_busy", 6'h04, 32'h1);
        base = pulse_cnt;
        wr_ok(6'h00, 32'h1);
        repeat (3) @(negedge clk);
        chk("start_while_busy", 128'(pulse_cnt - base), 128'(0));
        rd_chk("status_still_busy", 6'h04, 32'h1);
        axi_write(6'h00, 32'h4, 4'h0, r);
        repeat (3) @(negedge clk);
        chk("start_no_strobe", 128'(pulse_cnt - base), 128'(0));
        done_pulse();
        rd_chk("status_after_done", 6'h04, 32'h0);
        rd_chk("done_sticky", 6'h08, 32'h1);
        chk("irq_masked", 128'(irq), 128'(0));

        // interrupt and W1C
        wr_ok(6'h08, 32'h1);
        rd_chk("done_cleared", 6'h08, 32'h0);
        wr_ok(6'h0C, 32'h1);
        @(negedge clk);
        done_i = 4'b0001;
        @(negedge clk);
        done_i = 4'b0;
        chk("irq_latency0", 128'(irq), 128'(0));
        @(negedge clk);
        chk("irq_set", 128'(irq), 128'(1));
        wr_ok(6'h08, 32'h1);
        rd_chk("done_w1c", 6'h08, 32'h0);
        chk("irq_cleared", 128'(irq), 128'(0));
        bready = 1'b1;
        start_wr(6'h08, 32'h1, 4'hF);
        wait_aw(4'b0001);
        wait_b(r);
        rd_chk("done_set_wins", 6'h08, 32'h1);
        chk("irq_set_wins", 128'(irq), 128'(1));

        // write backpressure with a second write waiting
        bready = 1'b0;
        start_wr(6'h18, 32'h33, 4'hF);
        wait_aw(4'b0);
        awaddr = 6'h14; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_bvalid%0d", i), 128'(bvalid), 128'(1));
            chk($sformatf("bp_awready%0d", i), 128'(awready), 128'(0));
        end
        bready = 1'b1;
        wait_aw(4'b0);
        wait_b(r);
        chk("bp_second_bresp", 128'(r), 128'(0));
        rd_chk("bp_first_data", 6'h18, 32'h33);
        rd_chk("bp_second_data", 6'h14, 32'h55);

        // read backpressure, then reset with both responses pending
        bready = 1'b0;
        start_wr(6'h1C, 32'h9, 4'hF);
        wait_aw(4'b0);
        rready = 1'b0;
        axi_read(6'h10, d, r);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rbp_rvalid%0d", i), 128'(rvalid), 128'(1));
            chk($sformatf("rbp_rdata%0d", i), 128'(rdata),
                128'(32'h0000CC01));
        end
        chk("pre_rst_bvalid", 128'(bvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_bvalid", 128'(bvalid), 128'(0));
        chk("async_rst_rvalid", 128'(rvalid), 128'(0));
        chk("async_rst_irq", 128'(irq), 128'(0));
        chk("async_rst_user", user_regs, 128'(0));
        bready = 1'b1;
        rready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_user3", 6'h1C, 32'h0);
        rd_chk("post_rst_done", 6'h08, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
